// File: rtl/joystick_input.sv
// Debounced, synchronised joystick/button inputs exposed as three bus registers
// (stable state, sticky W1C press events, irq enable) plus a level interrupt.
module joystick_input #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       joystick_0,
    input  logic       joystick_1,
    input  logic       joystick_2,
    input  logic       joystick_3,
    input  logic       joystick_4,
    input  logic       button_select,
    input  logic       button_0,
    input  logic [1:0] address,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       enable,
    input  logic       write_enable,
    output logic       irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [6:0]         pins_n;
    logic [6:0]         meta_q, sync_q;
    logic [6:0]         stable_q, stable_d;
    logic [6:0]         pressed_q, pressed_d;
    logic [6:0]         irq_en_q, irq_en_d;
    logic [6:0][CW-1:0] cnt_q, cnt_d;
    logic [6:0]         sync_pressed, rise;
    logic [7:0]         rdata;
    logic               wr, rd;
    logic               unused_data7;

    assign pins_n = {button_0, button_select, joystick_4, joystick_3,
                     joystick_2, joystick_1, joystick_0};
    assign sync_pressed = ~sync_q;
    assign wr = enable & write_enable;
    assign rd = enable & ~write_enable;
    assign unused_data7 = data_in[7];

    // Per-input debounce: any cycle where sync matches stable restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 7; i++) begin
            if (sync_pressed[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync_pressed[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign rise = stable_d & ~stable_q;

    // A new press in the same cycle as a W1C of that bit leaves it set.
    always_comb begin
        pressed_d = pressed_q;
        irq_en_d  = irq_en_q;
        if (wr && address == 2'd1) pressed_d = pressed_q & ~data_in[6:0];
        if (wr && address == 2'd2) irq_en_d = data_in[6:0];
        pressed_d = pressed_d | rise;
    end

    always_comb begin
        case (address)
            2'd0:    rdata = {1'b0, stable_q};
            2'd1:    rdata = {1'b0, pressed_q};
            2'd2:    rdata = {1'b0, irq_en_q};
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q    <= '1;
            sync_q    <= '1;
            stable_q  <= '0;
            cnt_q     <= '0;
            pressed_q <= '0;
            irq_en_q  <= '0;
            data_out  <= 8'h00;
            irq       <= 1'b0;
        end else begin
            meta_q    <= pins_n;
            sync_q    <= meta_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            irq_en_q  <= irq_en_d;
            if (rd) data_out <= rdata;
            irq       <= |(pressed_q & irq_en_q);
        end
    end

endmodule

// File: doc/joystick_input.md
# joystick_input

Debounces and synchronises the console's active-low joystick lines and front-panel buttons. It presents them to the w65c832 peripheral bus as three byte-wide registers: a stable state register, a sticky press-event register and an interrupt enable. It sits between the board pins and the CPU's memory-mapped I/O decode, directly upstream of the core's joystick/button read path. It also drives a level interrupt request to the core.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 270000 — clock cycles an input must hold a new level before it is accepted (10 ms at 27 MHz); minimum 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- joystick_0  in  1  up, active-low.
- joystick_1  in  1  down, active-low.
- joystick_2  in  1  left, active-low.
- joystick_3  in  1  right, active-low.
- joystick_4  in  1  fire, active-low.
- button_select  in  1  select button, active-low.
- button_0  in  1  user button, active-low.
- address  in  2  register select: 0 state, 1 pressed, 2 irq_enable, 3 reserved.
- data_in  in  8  write data.
- data_out  out  8  read data, registered.
- enable  in  1  bus access strobe, one cycle per access.
- write_enable  in  1  qualifies enable: 1 write, 0 read.
- irq  out  1  level interrupt request, registered.

## Operation
- Bit map, shared by all registers: bit0 joystick_0, bit1 joystick_1, bit2 joystick_2, bit3 joystick_3, bit4 joystick_4, bit5 button_select, bit6 button_0, bit7 always 0.
- Synchroniser: each pin passes through two flops, then is inverted so that 1 means pressed (sync[i]).
- Debounce, per input, with an independent counter of width clog2(DEBOUNCE_CYCLES):
  - If sync[i] == stable[i], the counter is cleared to 0.
  - Else the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync[i] still differs, stable[i] <= sync[i] and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and never changes stable.
- Press detect: on a 0->1 transition of stable[i], pressed[i] sets. A 1->0 transition sets nothing.
- Register 0 (state): read-only, returns stable. Writes are ignored.
- Register 1 (pressed): reading returns pressed; reads do not clear it. A write clears every bit written as 1 (W1C). If a set and a W1C hit the same bit in the same cycle, the set wins (bit ends at 1).
- Register 2 (irq_enable): read/write, bits 6:0; bit7 reads 0.
- Register 3: reads 0x00; writes are ignored.
- irq <= |(pressed & irq_enable), evaluated from the post-update values of the previous cycle.
- Outputs on reset: data_out = 0x00 and irq = 0.
- State on reset:
  - Synchroniser flops load 1 (released level).
  - stable = 0, counters = 0, pressed = 0, irq_enable = 0.
  - A reset mid-debounce discards any partial count.
  - A button held through reset is reported as a new press DEBOUNCE_CYCLES+2 cycles after reset deasserts.

## Timing
- Pin-to-stable latency: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles. The stable bit changes on the edge after the counter reaches DEBOUNCE_CYCLES-1.
- pressed sets on the same edge that stable rises.
- irq asserts 1 cycle after pressed & irq_enable becomes non-zero. It deasserts 1 cycle after the clearing write or the irq_enable write.
- Read: enable=1, write_enable=0 in cycle N → data_out valid at cycle N+1 and held until the next read. Writes and idle cycles do not change data_out.
- Write: takes effect on the edge of the cycle in which enable=1 and write_enable=1. A read of the same register in the next cycle returns the new value.
- Bus accesses never stall; no wait states.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert reset 2 cycles with all pins high. Required: data_out=0x00, irq=0; reads of registers 0, 1, 2 return 0x00.
- Clean press: drive joystick_4 low at cycle 0 and hold it. Required: stable bit4 rises on the edge at cycle 6 (2+4). Reading register 0 returns 0x10 and register 1 returns 0x10.
- Glitch: pulse joystick_0 low for 3 cycles, then high. Required: register 0 stays 0x00, register 1 stays 0x00, irq stays 0.
- Interrupt and W1C:
  - Write 0x41 to register 2, then press button_0. Required: irq=1 one cycle after pressed bit6 sets.
  - Write 0x40 to register 1. Required: register 1 reads 0x00 and irq=0 one cycle later.
- Set/clear collision: time a W1C of bit1 to the exact cycle joystick_1's stable bit rises. Required: register 1 reads 0x02 afterwards.
- Reset mid-debounce: hold joystick_2 low, assert reset at debounce count 2, release reset with the pin still low. Required: register 0 reads 0x00 until 6 cycles after reset deassertion, then 0x04; register 1 reads 0x04.
